// File: rtl/md_alu_sequencer.sv
// Multi-cycle unsigned MULTU/DIVU/MTHI/MTLO sequencer that owns HI/LO.
// Every add/subtract step goes through the shared E-stage ALU.
module md_alu_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       md_op,
    input  logic [WIDTH-1:0] rs,
    input  logic [WIDTH-1:0] rt,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [2:0]       alu_op,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH-1:0] alu_y
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_DONE
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] dvsr;
    logic [WIDTH-1:0] rem;
    logic [CW-1:0]    cnt;
    logic             last;
    logic             top;
    logic             carry;
    logic             take;

    assign last  = (cnt == CW'(WIDTH - 1));
    assign rem   = {hi[WIDTH-2:0], lo[WIDTH-1]};
    assign top   = hi[WIDTH-1];
    assign carry = (alu_y < alu_a);
    // top set means the shifted remainder already exceeds WIDTH bits
    assign take  = top | (rem >= dvsr);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        busy     = 1'b0;
        done     = 1'b0;
        alu_op   = 3'b000;
        alu_a    = '0;
        alu_b    = '0;
        unique case (state)
            S_IDLE: begin
                if (start && md_op == 2'b00) begin
                    state_nx = S_MUL;
                end else if (start && md_op == 2'b01) begin
                    state_nx = S_DIV;
                end
            end
            S_MUL: begin
                busy  = 1'b1;
                alu_a = hi;
                alu_b = lo[0] ? mcand : '0;
                if (last) state_nx = S_DONE;
            end
            S_DIV: begin
                busy   = 1'b1;
                alu_op = 3'b001;
                alu_a  = rem;
                alu_b  = dvsr;
                if (last) state_nx = S_DONE;
            end
            S_DONE: begin
                busy     = 1'b1;
                done     = 1'b1;
                state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hi    <= '0;
            lo    <= '0;
            mcand <= '0;
            dvsr  <= '0;
            cnt   <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        unique case (md_op)
                            2'b00: begin
                                hi    <= '0;
                                lo    <= rt;
                                mcand <= rs;
                                cnt   <= '0;
                            end
                            2'b01: begin
                                hi   <= '0;
                                lo   <= rs;
                                dvsr <= rt;
                                cnt  <= '0;
                            end
                            2'b10: hi <= rs;
                            2'b11: lo <= rs;
                            default: ;
                        endcase
                    end
                end
                S_MUL: begin
                    hi  <= {carry, alu_y[WIDTH-1:1]};
                    lo  <= {alu_y[0], lo[WIDTH-1:1]};
                    cnt <= cnt + CW'(1);
                end
                S_DIV: begin
                    hi  <= take ? alu_y : rem;
                    lo  <= {lo[WIDTH-2:0], take};
                    cnt <= cnt + CW'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_md_alu_sequencer.sv
// Bench for md_alu_sequencer: acts as the ALU, models the step sequence
// cycle by cycle, and scoreboards final HI/LO at each done pulse.
module tb_md_alu_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  md_op = 2'b00;
    logic [31:0] rs = '0;
    logic [31:0] rt = '0;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [2:0]  alu_op;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [31:0] alu_y;

    int total = 0;
    int bad = 0;
    logic mon_en = 1'b0;

    md_alu_sequencer #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .start(start), .md_op(md_op),
        .rs(rs), .rt(rt), .busy(busy), .done(done), .hi(hi), .lo(lo),
        .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_y(alu_y)
    );

    always #5 clk = ~clk;

    assign alu_y = (alu_op == 3'b001) ? alu_a - alu_b : alu_a + alu_b;

    // reference model: 0 idle, 1 mul, 2 div, 3 done
    int          m_state = 0;
    int          m_cnt = 0;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;
    logic [31:0] m_mc = '0;
    logic [31:0] m_dv = '0;
    logic [63:0] sb[$];

    logic [32:0] m_sum;
    logic [64:0] m_acc;
    logic [32:0] m_r33;
    logic [32:0] m_sub;
    logic        m_ge;
    logic [2:0]  e_op;
    logic [31:0] e_a;
    logic [31:0] e_b;

    assign m_sum = {1'b0, m_hi} + {1'b0, (m_lo[0] ? m_mc : 32'h0)};
    assign m_acc = {m_sum, m_lo} >> 1;
    assign m_r33 = {m_hi, m_lo[31]};
    assign m_ge  = m_r33 >= {1'b0, m_dv};
    assign m_sub = m_r33 - {1'b0, m_dv};
    assign e_op  = (m_state == 2) ? 3'b001 : 3'b000;
    assign e_a   = (m_state == 1) ? m_hi :
                   (m_state == 2) ? m_r33[31:0] : 32'h0;
    assign e_b   = (m_state == 1) ? (m_lo[0] ? m_mc : 32'h0) :
                   (m_state == 2) ? m_dv : 32'h0;

    always @(posedge clk) begin
        if (reset) begin
            m_state <= 0;
            m_cnt   <= 0;
            m_hi    <= '0;
            m_lo    <= '0;
            sb.delete();
        end else begin
            case (m_state)
                0: if (start) begin
                    case (md_op)
                        2'b00: begin
                            m_state <= 1; m_hi <= '0; m_lo <= rt;
                            m_mc <= rs; m_cnt <= 0;
                            sb.push_back({32'h0, rs} * {32'h0, rt});
                        end
                        2'b01: begin
                            m_state <= 2; m_hi <= '0; m_lo <= rs;
                            m_dv <= rt; m_cnt <= 0;
                            if (rt == 0) sb.push_back({rs, 32'hFFFF_FFFF});
                            else sb.push_back({rs % rt, rs / rt});
                        end
                        2'b10: m_hi <= rs;
                        default: m_lo <= rs;
                    endcase
                end
                1: begin
                    m_hi  <= m_acc[63:32];
                    m_lo  <= m_acc[31:0];
                    m_cnt <= m_cnt + 1;
                    if (m_cnt == 31) m_state <= 3;
                end
                2: begin
                    m_hi  <= m_ge ? m_sub[31:0] : m_r33[31:0];
                    m_lo  <= {m_lo[30:0], m_ge};
                    m_cnt <= m_cnt + 1;
                    if (m_cnt == 31) m_state <= 3;
                end
                default: m_state <= 0;
            endcase
        end
    end

    always @(negedge clk) begin
        if (mon_en) begin
            total++;
            if ({alu_op, alu_a, alu_b} !== {e_op, e_a, e_b}) begin
                bad++;
                $display("FAIL alu t=%0t got op=%h a=%h b=%h want op=%h a=%h b=%h",
                         $time, alu_op, alu_a, alu_b, e_op, e_a, e_b);
            end
            total++;
            if ({busy, done} !== {m_state != 0, m_state == 3}) begin
                bad++;
                $display("FAIL busy_done t=%0t got %b%b want %b%b", $time,
                         busy, done, m_state != 0, m_state == 3);
            end
            total++;
            if ({hi, lo} !== {m_hi, m_lo}) begin
                bad++;
                $display("FAIL hilo_track t=%0t got %h_%h want %h_%h",
                         $time, hi, lo, m_hi, m_lo);
            end
            if (done === 1'b1) begin
                total++;
                if (sb.size() == 0) begin
                    bad++;
                    $display("FAIL sb_empty t=%0t got done=1 want no done", $time);
                end else begin
                    logic [63:0] exp;
                    exp = sb.pop_front();
                    if ({hi, lo} !== exp) begin
                        bad++;
                        $display("FAIL sb_result got %h_%h want %h", hi, lo, exp);
                    end
                end
            end
        end
    end

    task automatic issue(input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b);
        @(posedge clk); #1;
        start = 1'b1; md_op = op; rs = a; rt = b;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(output int k, output int nb);
        k = -1;
        nb = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (busy === 1'b1) nb++;
            if (done === 1'b1) begin
                k = i;
                break;
            end
        end
        total++;
        if (k < 0) begin
            bad++;
            $display("FAIL done_timeout got none want done within 40");
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++;
        if ({busy, done, hi, lo, alu_op, alu_a, alu_b} !== '0) begin
            bad++;
            $display("FAIL reset got busy=%b done=%b hi=%h lo=%h op=%h a=%h b=%h want 0",
                     busy, done, hi, lo, alu_op, alu_a, alu_b);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        mon_en = 1'b1;
    endtask

    task automatic test_mul_max;
        int k, nb;
        issue(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done(k, nb);
        total++;
        if (k != 33) begin
            bad++;
            $display("FAIL mul_latency got %0d want 33", k);
        end
        total++;
        if ({hi, lo} !== 64'hFFFF_FFFE_0000_0001) begin
            bad++;
            $display("FAIL mul_max got %h_%h want fffffffe_00000001", hi, lo);
        end
    endtask

    task automatic test_div;
        int k, nb;
        issue(2'b01, 32'd100, 32'd7);
        wait_done(k, nb);
        total++;
        if ({hi, lo} !== {32'd2, 32'd14}) begin
            bad++;
            $display("FAIL div_100_7 got hi=%0d lo=%0d want hi=2 lo=14", hi, lo);
        end
        total++;
        if (nb != 33) begin
            bad++;
            $display("FAIL div_busy_len got %0d want 33", nb);
        end
        @(negedge clk);
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL div_busy_drop got %b want 0", busy);
        end
    endtask

    task automatic test_div_zero;
        int k, nb;
        issue(2'b01, 32'h8000_0000, 32'h0);
        wait_done(k, nb);
        total++;
        if ({hi, lo} !== 64'h8000_0000_FFFF_FFFF) begin
            bad++;
            $display("FAIL div_zero got %h_%h want 80000000_ffffffff", hi, lo);
        end
    endtask

    task automatic test_mt;
        @(posedge clk); #1;
        start = 1'b1; md_op = 2'b10; rs = 32'h1234;
        @(posedge clk); #1;
        md_op = 2'b11; rs = 32'h5678;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        total++;
        if ({busy, hi, lo} !== {1'b0, 32'h1234, 32'h5678}) begin
            bad++;
            $display("FAIL mt got busy=%b hi=%h lo=%h want 0 1234 5678",
                     busy, hi, lo);
        end
    endtask

    task automatic test_ignore_start;
        int k, nb;
        issue(2'b00, 32'd3, 32'd5);
        repeat (8) @(posedge clk);
        #1;
        start = 1'b1; md_op = 2'b01; rs = 32'd99; rt = 32'd3;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(k, nb);
        total++;
        if ({hi, lo} !== {32'd0, 32'd15}) begin
            bad++;
            $display("FAIL ignore_start got hi=%h lo=%h want 0 f", hi, lo);
        end
        @(negedge clk);
        @(negedge clk);
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL ignore_queued got busy=%b want 0", busy);
        end
    endtask

    task automatic test_reset_mid;
        int nd;
        issue(2'b01, 32'd1000, 32'd3);
        repeat (15) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        total++;
        if ({busy, done, hi, lo} !== '0) begin
            bad++;
            $display("FAIL reset_mid got busy=%b done=%b hi=%h lo=%h want 0",
                     busy, done, hi, lo);
        end
        nd = 0;
        repeat (40) begin
            @(negedge clk);
            if (done === 1'b1) nd++;
        end
        total++;
        if (nd != 0) begin
            bad++;
            $display("FAIL reset_no_done got %0d pulses want 0", nd);
        end
    endtask

    task automatic test_back_to_back;
        int k, nb;
        logic [31:0] a, b;
        logic [1:0] op;
        logic [63:0] exp;
        for (int i = 0; i < 6; i++) begin
            op = 2'($urandom_range(0, 1));
            a = $urandom();
            b = (i % 2 == 0) ? 32'($urandom_range(1, 300)) : $urandom();
            if (op == 2'b00) exp = {32'h0, a} * {32'h0, b};
            else exp = {a % b, a / b};
            issue(op, a, b);
            wait_done(k, nb);
            total++;
            if ({hi, lo} !== exp) begin
                bad++;
                $display("FAIL b2b_%0d op=%0d a=%h b=%h got %h_%h want %h",
                         i, op, a, b, hi, lo, exp);
            end
        end
    endtask

    initial begin
        test_reset();
        test_mul_max();
        test_div();
        test_div_zero();
        test_mt();
        test_ignore_start();
        test_reset_mid();
        test_back_to_back();
        repeat (3) @(negedge clk);
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL sb_leftover got %0d want 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
